// File: rtl/lbp_hist_if.sv
// lbp_hist_if: bundle of the LBP result snoop port and the histogram drain port.
//   slave  modport: the histogram block (consumes lbp_*, finish and hist_ready).
//   master modport: the environment (drives the engine side and the downstream ready).
//   lbp_valid/lbp_addr/lbp_data : engine result strobe, pixel address and LBP code
//   finish                      : engine frame-complete level
//   hist_valid/ready/bin/count  : bin drain handshake and payload
//   hist_total                  : results accumulated this frame
//   hist_done                   : all bins accepted (sticky)
//   seq_err/late_err            : sticky debug flags
interface lbp_hist_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 14,
  parameter int CNT_W  = 15
) ();
  logic              lbp_valid;
  logic [ADDR_W-1:0] lbp_addr;
  logic [DATA_W-1:0] lbp_data;
  logic              finish;
  logic              hist_ready;
  logic              hist_valid;
  logic [DATA_W-1:0] hist_bin;
  logic [CNT_W-1:0]  hist_count;
  logic [CNT_W-1:0]  hist_total;
  logic              hist_done;
  logic              seq_err;
  logic              late_err;

  modport slave (
    input  lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
    output hist_valid, hist_bin, hist_count, hist_total, hist_done, seq_err, late_err
  );

  modport master (
    output lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
    input  hist_valid, hist_bin, hist_count, hist_total, hist_done, seq_err, late_err
  );
endinterface

// File: rtl/lbp_hist.sv
// lbp_hist: 256-bin histogram of LBP codes for one 128x128 frame.
// Snoops the LBP engine result write port while in ACCUM, then after finish
// drains bins 0..255 over a valid/ready port, then parks in DONE until reset.
// Ports:
//   clk     : system clock, rising edge
//   reset   : synchronous, active-high; aborts any frame in progress
//   hist_if : lbp_hist_if.slave (result snoop inputs, drain port, status flags)
module lbp_hist #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 14,
  parameter int CNT_W  = 15
) (
  input  logic         clk,
  input  logic         reset,
  lbp_hist_if.slave    hist_if
);
  localparam int NBINS = 2 ** DATA_W;
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [DATA_W-1:0] LAST_BIN = {DATA_W{1'b1}};

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bin_q [NBINS];
  logic [CNT_W-1:0]  total_q;
  logic [DATA_W-1:0] idx_q;
  logic [ADDR_W-1:0] last_addr_q;
  logic              first_q;
  logic              seq_err_q;
  logic              late_err_q;
  logic              accept_s;
  logic              valid_s;
  logic              done_s;

  // Saturating +1 so a pathological frame never wraps a counter back to small values.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and drain-port handshake qualification.
  always_comb begin
    state_d  = state_q;
    accept_s = 1'b0;
    valid_s  = 1'b0;
    done_s   = 1'b0;
    case (state_q)
      ACCUM: begin
        if (hist_if.finish) begin
          state_d = DRAIN;
        end else begin
          state_d = ACCUM;
        end
      end
      DRAIN: begin
        valid_s = 1'b1;
        if (hist_if.hist_ready) begin
          accept_s = 1'b1;
          if (idx_q == LAST_BIN) begin
            state_d = DONE;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        done_s  = 1'b1;
        state_d = DONE;
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // Bin array, total, drain index and debug flags.
  // Each strobe reads and writes the bin register in the same edge, so back-to-back
  // hits to one bin always see the previous increment (no read-modify-write hazard).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NBINS; i++) begin
        bin_q[i] <= '0;
      end
      total_q     <= '0;
      idx_q       <= '0;
      last_addr_q <= '0;
      first_q     <= 1'b1;
      seq_err_q   <= 1'b0;
      late_err_q  <= 1'b0;
    end else begin
      if (hist_if.lbp_valid && (state_q == ACCUM)) begin
        bin_q[hist_if.lbp_data] <= sat_inc(bin_q[hist_if.lbp_data]);
        total_q                 <= sat_inc(total_q);
        if (!first_q && (hist_if.lbp_addr <= last_addr_q)) begin
          seq_err_q <= 1'b1;
        end
        last_addr_q <= hist_if.lbp_addr;
        first_q     <= 1'b0;
      end
      if (hist_if.lbp_valid && (state_q != ACCUM)) begin
        late_err_q <= 1'b1;
      end
      if (accept_s) begin
        idx_q <= idx_q + DATA_W'(1);
      end
    end
  end

  // hist_count is read straight from the bin registers, so it tracks idx_q with no extra cycle.
  assign hist_if.hist_valid = valid_s;
  assign hist_if.hist_bin   = idx_q;
  assign hist_if.hist_count = valid_s ? bin_q[idx_q] : '0;
  assign hist_if.hist_total = total_q;
  assign hist_if.hist_done  = done_s;
  assign hist_if.seq_err    = seq_err_q;
  assign hist_if.late_err   = late_err_q;
endmodule

// File: tb/tb_lbp_hist.sv
// Scoreboard bench for lbp_hist: the driver keeps a frame-level model (per-code
// counts, address order, late strobes) and pushes the 256 expected bins when finish
// is issued; an independent monitor pops and compares on every drain handshake.
module tb_lbp_hist;
  logic clk;
  logic reset;

  lbp_hist_if bus ();

  lbp_hist dut (
    .clk     (clk),
    .reset   (reset),
    .hist_if (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b;
    logic [14:0] c;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   hs_cnt      = 0;
  int   last_hs_cyc = 0;

  int   model_cnt [256];
  int   model_total;
  bit   model_accum;
  bit   model_seq;
  bit   model_late;
  bit   have_last;
  int   last_addr;

  logic        held;
  logic [7:0]  held_b;
  logic [14:0] held_c;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: stability while stalled, and scoreboard pop on each handshake.
  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_bin", bus.hist_bin, held_b);
        check("hold_cnt", bus.hist_count, held_c);
      end
      held = 1'b0;
      if (bus.hist_valid && bus.hist_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_bin: got bin %0d, expected no output", bus.hist_bin);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("drain_bin", bus.hist_bin, e.b);
          check("drain_cnt", bus.hist_count, e.c);
        end
        hs_cnt++;
        last_hs_cyc = cyc;
      end else if (bus.hist_valid) begin
        held   = 1'b1;
        held_b = bus.hist_bin;
        held_c = bus.hist_count;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.lbp_valid  = 1'b0;
    bus.lbp_addr   = '0;
    bus.lbp_data   = '0;
    bus.finish     = 1'b0;
    bus.hist_ready = 1'b0;
    tick();
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 256; i++) model_cnt[i] = 0;
    model_total = 0;
    model_accum = 1'b1;
    model_seq   = 1'b0;
    model_late  = 1'b0;
    have_last   = 1'b0;
    last_addr   = 0;
    hs_cnt      = 0;
  endtask

  task automatic push_expected();
    for (int b = 0; b < 256; b++) begin
      exp_t e;
      int   c;
      c   = (model_cnt[b] > 32767) ? 32767 : model_cnt[b];
      e.b = b[7:0];
      e.c = c[14:0];
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input int a, input int d, input bit fin);
    bus.lbp_valid = 1'b1;
    bus.lbp_addr  = a[13:0];
    bus.lbp_data  = d[7:0];
    if (fin) bus.finish = 1'b1;
    if (model_accum) begin
      model_cnt[d]++;
      model_total++;
      if (have_last && (a <= last_addr)) model_seq = 1'b1;
      last_addr = a;
      have_last = 1'b1;
      if (fin) begin
        model_accum = 1'b0;
        push_expected();
      end
    end else begin
      model_late = 1'b1;
    end
    tick();
    bus.lbp_valid = 1'b0;
    if (fin) check("valid_latency", bus.hist_valid, 1);
  endtask

  task automatic do_finish();
    bus.finish = 1'b1;
    if (model_accum) begin
      model_accum = 1'b0;
      push_expected();
    end
    tick();
    check("valid_latency", bus.hist_valid, 1);
  endtask

  task automatic check_flags();
    int t;
    t = (model_total > 32767) ? 32767 : model_total;
    check("total", bus.hist_total, t);
    check("seq_err", bus.seq_err, model_seq);
    check("late_err", bus.late_err, model_late);
  endtask

  // mode 0: ready high; mode 1: ready 1,0,0,1 repeating; otherwise random ready.
  task automatic drain(input int mode, input int stop_at);
    int n;
    n = 0;
    while (!bus.hist_done && (hs_cnt < stop_at) && (n < 3000)) begin
      case (mode)
        0:       bus.hist_ready = 1'b1;
        1:       bus.hist_ready = ((n % 4) == 0) || ((n % 4) == 3);
        default: bus.hist_ready = ($urandom_range(0, 1) == 1);
      endcase
      tick();
      n++;
    end
    if (n >= 3000) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d handshakes, expected %0d", hs_cnt, stop_at);
    end
    if (stop_at >= 256) begin
      check("done", bus.hist_done, 1);
      check("done_latency", cyc, last_hs_cyc + 1);
      check("hs_count", hs_cnt, 256);
      check("queue_empty", exp_q.size(), 0);
      check("valid_after_done", bus.hist_valid, 0);
    end
    bus.hist_ready = 1'b0;
  endtask

  initial begin
    int a;
    int n;
    do_reset();
    check("rst_valid", bus.hist_valid, 0);
    check("rst_bin", bus.hist_bin, 0);
    check("rst_count", bus.hist_count, 0);
    check("rst_total", bus.hist_total, 0);
    check("rst_done", bus.hist_done, 0);
    check("rst_seq", bus.seq_err, 0);
    check("rst_late", bus.late_err, 0);

    // Full frame, every result in bin 0.
    for (int i = 0; i < 16384; i++) send(i, 0, 1'b0);
    do_finish();
    check_flags();
    drain(0, 256);
    check_flags();

    // Small frame, ready held high, then the same frame with a stalling consumer.
    for (int m = 0; m < 2; m++) begin
      do_reset();
      send(0, 5, 1'b0);
      send(1, 5, 1'b0);
      send(2, 255, 1'b0);
      send(3, 5, 1'b0);
      do_finish();
      drain(m, 256);
      check_flags();
    end

    // Address ordering.
    do_reset();
    send(10, 1, 1'b0);
    check("seq_1", bus.seq_err, 0);
    send(11, 2, 1'b0);
    check("seq_2", bus.seq_err, 0);
    send(11, 3, 1'b0);
    check("seq_3", bus.seq_err, 1);
    send(9, 4, 1'b0);
    check("seq_4", bus.seq_err, 1);
    check("seq_total", bus.hist_total, 4);
    do_finish();
    drain(2, 256);
    check_flags();

    // finish coincident with a strobe, then a late strobe during DRAIN and in DONE.
    do_reset();
    send(0, 32, 1'b1);
    check("late_pre", bus.late_err, 0);
    send(1, 32, 1'b0);
    check("late_set", bus.late_err, 1);
    drain(0, 256);
    send(2, 7, 1'b0);
    check_flags();
    check("late_total", bus.hist_total, 1);

    // Randomized frames.
    for (int f = 0; f < 4; f++) begin
      do_reset();
      n = $urandom_range(30, 400);
      a = $urandom_range(0, 50);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) tick();
        a = (a + $urandom_range(0, 40)) % 16384;
        send(a, (i % 2 == 1) ? $urandom_range(0, 255) : $urandom_range(0, 7),
             (i == n - 1) && (f % 2 == 1));
      end
      if (f % 2 == 0) do_finish();
      if ($urandom_range(0, 1) == 1) send(a + 1, 3, 1'b0);
      check_flags();
      drain(2, 256);
      check_flags();
    end

    // Abort mid-drain with both sticky flags set, then a clean short frame.
    do_reset();
    send(5, 1, 1'b0);
    send(4, 2, 1'b0);
    do_finish();
    send(6, 3, 1'b0);
    drain(0, 100);
    check("abort_bin", bus.hist_bin, 100);
    check("abort_flags", {bus.seq_err, bus.late_err}, 2'b11);
    do_reset();
    check("abort_valid", bus.hist_valid, 0);
    check("abort_seq", bus.seq_err, 0);
    check("abort_late", bus.late_err, 0);
    check("abort_done", bus.hist_done, 0);
    check("abort_total", bus.hist_total, 0);
    send(0, 9, 1'b0);
    send(1, 9, 1'b0);
    send(2, 200, 1'b0);
    do_finish();
    drain(0, 256);
    check_flags();
    check("abort_new_total", bus.hist_total, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
